// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: four RGB LEDs driven by 8-bit PWM, updated by commands only at frame boundaries
// clk_100mhz/rst_n     : clock, asynchronous active-low reset
// cmd_valid/cmd_ready  : command handshake; cmd_ready is low while a command waits for the frame boundary
// cmd_all/cmd_led      : target all LEDs, or the single LED cmd_led
// cmd_r/cmd_g/cmd_b    : per-colour duty, 0 = off, 255 = on for 255/256 of the frame
// cmd_blink            : gate the target LED with the blink phase
// ledR/ledG/ledB       : registered LED drives, bit n is LED n
// frame_start          : one-cycle pulse on the first cycle of each PWM frame
module rgb_pwm_driver #(
   parameter int PRESCALE   = 390,
   parameter int BLINK_BIT  = 26,
   parameter int ACTIVE_LOW = 1
) (
   input  logic       clk_100mhz,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_all,
   input  logic [1:0] cmd_led,
   input  logic [7:0] cmd_r,
   input  logic [7:0] cmd_g,
   input  logic [7:0] cmd_b,
   input  logic       cmd_blink,
   output logic [3:0] ledR,
   output logic [3:0] ledG,
   output logic [3:0] ledB,
   output logic       frame_start
);
   localparam logic OFF = (ACTIVE_LOW != 0);
   typedef enum logic {IDLE, PENDING} state_t;
   state_t      state;
   logic [15:0] presc;
   logic [7:0]  pwm_cnt;
   logic [31:0] blink_cnt;
   logic        step;
   logic        boundary;
   logic [7:0]  duty_r [4];
   logic [7:0]  duty_g [4];
   logic [7:0]  duty_b [4];
   logic [3:0]  blink_f;
   logic        sh_all;
   logic [1:0]  sh_led;
   logic [7:0]  sh_r;
   logic [7:0]  sh_g;
   logic [7:0]  sh_b;
   logic        sh_blink;
   logic [3:0]  on_r;
   logic [3:0]  on_g;
   logic [3:0]  on_b;

   assign step     = presc == 16'(PRESCALE - 1);
   // last cycle of the frame: the only point where active registers may change
   assign boundary = step && pwm_cnt == 8'hFF;

   always_comb begin
      on_r = '0;
      on_g = '0;
      on_b = '0;
      for (int i = 0; i < 4; i++) begin
         on_r[i] = (pwm_cnt < duty_r[i]) && (!blink_f[i] || blink_cnt[BLINK_BIT]);
         on_g[i] = (pwm_cnt < duty_g[i]) && (!blink_f[i] || blink_cnt[BLINK_BIT]);
         on_b[i] = (pwm_cnt < duty_b[i]) && (!blink_f[i] || blink_cnt[BLINK_BIT]);
      end
   end

   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         presc       <= '0;
         pwm_cnt     <= '0;
         blink_cnt   <= '0;
         frame_start <= 1'b0;
         ledR        <= {4{OFF}};
         ledG        <= {4{OFF}};
         ledB        <= {4{OFF}};
      end else begin
         presc       <= step ? '0 : presc + 16'd1;
         pwm_cnt     <= pwm_cnt + 8'(step);
         blink_cnt   <= blink_cnt + 32'd1;
         frame_start <= boundary;
         ledR        <= on_r ^ {4{OFF}};
         ledG        <= on_g ^ {4{OFF}};
         ledB        <= on_b ^ {4{OFF}};
      end
   end

   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cmd_ready <= 1'b0;
         sh_all    <= 1'b0;
         sh_led    <= '0;
         sh_r      <= '0;
         sh_g      <= '0;
         sh_b      <= '0;
         sh_blink  <= 1'b0;
         blink_f   <= '0;
         for (int i = 0; i < 4; i++) begin
            duty_r[i] <= '0;
            duty_g[i] <= '0;
            duty_b[i] <= '0;
         end
      end else if (state == IDLE) begin
         cmd_ready <= 1'b1;
         if (cmd_valid && cmd_ready) begin
            sh_all    <= cmd_all;
            sh_led    <= cmd_led;
            sh_r      <= cmd_r;
            sh_g      <= cmd_g;
            sh_b      <= cmd_b;
            sh_blink  <= cmd_blink;
            state     <= PENDING;
            cmd_ready <= 1'b0;
         end
      end else if (boundary) begin
         for (int i = 0; i < 4; i++) begin
            if (sh_all || sh_led == 2'(i)) begin
               duty_r[i]  <= sh_r;
               duty_g[i]  <= sh_g;
               duty_b[i]  <= sh_b;
               blink_f[i] <= sh_blink;
            end
         end
         state     <= IDLE;
         cmd_ready <= 1'b1;
      end
   end
endmodule
